pad_config_sequencer: RTL and testbench

- Holds per-pad configuration (CS, SL, IE, OE, PU, PD, PDRV0, PDRV1) for the 46 bidirectional padframe I/Os and drives the padframe's per-bit configuration buses.
- Software writes a shadow copy through a valid/ready port, then issues a commit.
- A sequencer applies the commit glitch-safely: it disables outputs on changed pads, settles, updates the electrical fields, settles again, and re-enables outputs.
- Sits in the core between the host register interface and the padframe bidir configuration inputs.

---
 rtl/pad_config_sequencer_if.sv | 30 +++
 rtl/pad_config_sequencer.sv | 144 ++++++++++++++
 tb/tb_pad_config_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_config_sequencer_if.sv
// Host-side bus for pad_config_sequencer.
// Groups the shadow write port, the shadow readback port and the commit
// handshake with its status outputs.
//   master : host / register block (drives requests, observes status)
//   slave  : pad_config_sequencer
interface pad_config_sequencer_if #(
  parameter int AW = 6
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_err;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          commit_valid;
  logic          commit_ready;
  logic          busy;
  logic          commit_done;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_addr, commit_valid,
    input  wr_ready, wr_err, rd_data, commit_ready, busy, commit_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_addr, commit_valid,
    output wr_ready, wr_err, rd_data, commit_ready, busy, commit_done
  );
endinterface

// File: rtl/pad_config_sequencer.sv
// Per-pad configuration holder and glitch-safe commit sequencer for the
// padframe bidirectional I/Os.
// Software fills a shadow copy (one 8-bit word per pad:
// [0]OE [1]IE [2]PU [3]PD [4]PDRV0 [5]PDRV1 [6]SL [7]CS) and then commits.
// The commit disables OE on changed pads, waits SETTLE cycles, updates the
// electrical fields, waits SETTLE cycles again, then restores OE.
// Ports:
//   clk, rst      : core clock, asynchronous active-high reset
//   bus (slave)   : shadow write/readback and commit handshake + status
//   pad_*         : active per-pad configuration buses, all flop outputs
module pad_config_sequencer #(
  parameter int NPADS  = 46,
  parameter int SETTLE = 4,
  parameter int AW     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  pad_config_sequencer_if.slave bus,
  output logic [NPADS-1:0]     pad_oe,
  output logic [NPADS-1:0]     pad_ie,
  output logic [NPADS-1:0]     pad_pu,
  output logic [NPADS-1:0]     pad_pd,
  output logic [NPADS-1:0]     pad_pdrv0,
  output logic [NPADS-1:0]     pad_pdrv1,
  output logic [NPADS-1:0]     pad_sl,
  output logic [NPADS-1:0]     pad_cs
);

  localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [AW:0]     NPADS_W     = (AW + 1)'(NPADS);
  localparam logic [7:0]      RST_WORD    = 8'h02;

  typedef enum logic [2:0] {
    IDLE, QUIESCE, SETTLE1, UPDATE, SETTLE2, ENABLE, DONE
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [7:0]        shadow [NPADS];
  logic [NPADS-1:0]  chg, chg_now;
  logic [7:0]        rd_q;
  logic              err_q;
  logic              wr_fire, wr_in_range, rd_in_range;

  assign wr_fire     = bus.wr_valid && (state == IDLE);
  assign wr_in_range = {1'b0, bus.wr_addr} < NPADS_W;
  assign rd_in_range = {1'b0, bus.rd_addr} < NPADS_W;

  assign bus.wr_ready     = (state == IDLE);
  assign bus.commit_ready = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.commit_done  = (state == DONE);
  assign bus.rd_data      = rd_q;
  assign bus.wr_err       = err_q;

  // A pad counts as changed if any of its eight fields differ between the
  // shadow and the currently driven (active) configuration.
  always_comb begin
    chg_now = '0;
    for (int unsigned i = 0; i < NPADS; i++) begin
      chg_now[i] = shadow[i] != {pad_cs[i], pad_sl[i], pad_pdrv1[i], pad_pdrv0[i],
                                 pad_pd[i], pad_pu[i], pad_ie[i], pad_oe[i]};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.commit_valid) state_nx = QUIESCE;
      QUIESCE: state_nx = (|chg_now) ? SETTLE1 : DONE;
      SETTLE1: if (cnt == '0) state_nx = UPDATE;
      UPDATE:  state_nx = SETTLE2;
      SETTLE2: if (cnt == '0) state_nx = ENABLE;
      ENABLE:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counter is loaded in the single cycle before each settle phase so that
  // each settle state lasts exactly SETTLE cycles (SETTLE-1 down to 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      chg   <= '0;
    end else begin
      state <= state_nx;
      if (state == QUIESCE) chg <= chg_now;
      if (state == QUIESCE || state == UPDATE) cnt <= SETTLE_LOAD;
      else if (cnt != '0)                      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPADS; i++) shadow[i] <= RST_WORD;
      rd_q  <= RST_WORD;
      err_q <= 1'b0;
    end else begin
      err_q <= wr_fire && !wr_in_range;
      if (wr_fire && wr_in_range) shadow[bus.wr_addr] <= bus.wr_data;
      rd_q <= rd_in_range ? shadow[bus.rd_addr] : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_oe    <= '0;
      pad_ie    <= '1;
      pad_pu    <= '0;
      pad_pd    <= '0;
      pad_pdrv0 <= '0;
      pad_pdrv1 <= '0;
      pad_sl    <= '0;
      pad_cs    <= '0;
    end else begin
      case (state)
        QUIESCE: pad_oe <= pad_oe & ~chg_now;
        UPDATE: begin
          for (int unsigned i = 0; i < NPADS; i++) begin
            if (chg[i]) begin
              pad_ie[i]    <= shadow[i][1];
              pad_pu[i]    <= shadow[i][2];
              pad_pd[i]    <= shadow[i][3];
              pad_pdrv0[i] <= shadow[i][4];
              pad_pdrv1[i] <= shadow[i][5];
              pad_sl[i]    <= shadow[i][6];
              pad_cs[i]    <= shadow[i][7];
            end
          end
        end
        ENABLE: begin
          for (int unsigned i = 0; i < NPADS; i++) begin
            if (chg[i]) pad_oe[i] <= shadow[i][0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_config_sequencer.sv
module tb_pad_config_sequencer;
  localparam int NPADS  = 46;
  localparam int SETTLE = 4;
  localparam int AW     = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NPADS-1:0] pad_oe, pad_ie, pad_pu, pad_pd, pad_pdrv0, pad_pdrv1, pad_sl, pad_cs;

  pad_config_sequencer_if #(.AW(AW)) bus ();

  pad_config_sequencer #(.NPADS(NPADS), .SETTLE(SETTLE), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_pu(pad_pu), .pad_pd(pad_pd),
    .pad_pdrv0(pad_pdrv0), .pad_pdrv1(pad_pdrv1), .pad_sl(pad_sl), .pad_cs(pad_cs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: shadow and active words per pad, plus the timeline of
  // the most recent commit (accept cycle, changed set, before/after words).
  logic [7:0] m_shadow [NPADS];
  logic [7:0] m_act    [NPADS];
  logic [7:0] o_act    [NPADS];
  logic [7:0] n_act    [NPADS];
  bit         chg      [NPADS];
  bit         c_act    = 1'b0;
  int         c_a      = 0;
  int         done_k   = 0;
  int         acc_cnt  = 0;

  typedef struct {int c; logic [7:0] rd; logic err;} rexp_t;
  rexp_t rq[$];
  int    dq[$];

  string fname [8] = '{"pad_oe", "pad_ie", "pad_pu", "pad_pd",
                       "pad_pdrv0", "pad_pdrv1", "pad_sl", "pad_cs"};

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, got, exp);
    end
  endtask

  function automatic bit busy_at(int c);
    int k = c - c_a + 1;
    return c_act && k >= 1 && k <= done_k;
  endfunction

  // Expected value of one field bus in observed cycle c, from the latency
  // rules: OE drops on changed pads from cycle 2, electrical fields switch
  // at cycle SETTLE+3, new OE appears at cycle 2*SETTLE+4.
  function automatic logic [63:0] exp_field(int f, int c);
    logic [63:0] r = '0;
    logic [7:0]  w;
    int          k = c - c_a + 1;
    for (int i = 0; i < NPADS; i++) begin
      if (!c_act) w = m_act[i];
      else begin
        w = (k < SETTLE + 3) ? o_act[i] : n_act[i];
        if (chg[i] && k >= 2 && k < 2 * SETTLE + 4) w[0] = 1'b0;
      end
      r[i] = w[f];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPADS; i++) begin
      m_shadow[i] = 8'h02;
      m_act[i]    = 8'h02;
    end
    c_act = 1'b0;
    dq.delete();
  endtask

  // Model: evaluates each upcoming clock edge 1ns before it happens.
  initial begin
    rexp_t e;
    bit    idle, any;
    int    wa, ra;
    model_reset();
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        model_reset();
        e.c = cyc + 1; e.rd = 8'h02; e.err = 1'b0;
        rq.push_back(e);
        continue;
      end
      idle = !busy_at(cyc);
      wa   = int'(bus.wr_addr);
      ra   = int'(bus.rd_addr);
      e.c   = cyc + 1;
      e.rd  = (ra < NPADS) ? m_shadow[ra] : 8'h00;
      e.err = bus.wr_valid && idle && (wa >= NPADS);
      rq.push_back(e);
      if (bus.wr_valid && idle && wa < NPADS) m_shadow[wa] = bus.wr_data;
      if (bus.commit_valid && idle) begin
        acc_cnt++;
        any = 1'b0;
        for (int i = 0; i < NPADS; i++) begin
          o_act[i] = m_act[i];
          n_act[i] = m_shadow[i];
          chg[i]   = m_shadow[i] != m_act[i];
          any      = any | chg[i];
          m_act[i] = m_shadow[i];
        end
        c_a    = cyc + 1;
        c_act  = 1'b1;
        done_k = any ? 2 * SETTLE + 4 : 2;
        dq.push_back(c_a + done_k - 1);
      end
    end
  end

  // Monitor: samples 1ns after every rising edge and pops the scoreboard.
  initial begin
    logic [NPADS-1:0] got [8];
    rexp_t e;
    bit    exp_done;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (rq.size() > 0 && rq[0].c < cyc) void'(rq.pop_front());
      if (rq.size() > 0 && rq[0].c == cyc) begin
        e = rq.pop_front();
        chk("rd_data", 64'(bus.rd_data), 64'(e.rd));
        chk("wr_err", 64'(bus.wr_err), 64'(e.err));
      end
      chk("busy", 64'(bus.busy), 64'(busy_at(cyc)));
      chk("commit_ready", 64'(bus.commit_ready), 64'(!busy_at(cyc)));
      chk("wr_ready", 64'(bus.wr_ready), 64'(!busy_at(cyc)));
      exp_done = dq.size() > 0 && dq[0] == cyc;
      chk("commit_done", 64'(bus.commit_done), 64'(exp_done));
      while (dq.size() > 0 && dq[0] <= cyc) void'(dq.pop_front());
      got[0] = pad_oe;    got[1] = pad_ie;    got[2] = pad_pu;  got[3] = pad_pd;
      got[4] = pad_pdrv0; got[5] = pad_pdrv1; got[6] = pad_sl;  got[7] = pad_cs;
      for (int f = 0; f < 8; f++) chk(fname[f], 64'(got[f]), exp_field(f, cyc));
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic nxt();
    @(negedge clk);
    bus.rd_addr = AW'($urandom_range(0, 63));
  endtask

  task automatic wait_idle();
    int n = 0;
    nxt();
    while (busy_at(cyc) && n < 200) begin nxt(); n++; end
  endtask

  task automatic do_write(int a, int d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(a);
    bus.wr_data  = 8'(d);
    nxt();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_accept(int n0);
    int n = 0;
    while (acc_cnt == n0 && n < 300) begin nxt(); n++; end
    if (acc_cnt == n0) begin
      checks++; errors++;
      $display("FAIL commit_accept cyc=%0d actual=not_accepted required=accepted", cyc);
    end
    bus.commit_valid = 1'b0;
  endtask

  task automatic do_commit();
    int n0 = acc_cnt;
    bus.commit_valid = 1'b1;
    nxt();
    wait_accept(n0);
  endtask

  task automatic read_all();
    for (int a = 0; a < NPADS; a++) begin
      nxt();
      bus.rd_addr = AW'(a);
    end
  endtask

  initial begin
    int n0, n;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.commit_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    read_all();
    nxt(); bus.rd_addr = AW'(50);

    // Two pads with electrical changes, pad 40 also enables OE.
    wait_idle(); do_write(5, 8'h87);
    do_write(40, 8'h0D);
    do_commit();

    // Pad 5 already driving: OE must drop around the PU change.
    wait_idle(); do_write(5, 8'h13);
    do_commit();

    // Nothing changed: short commit.
    wait_idle(); do_commit();

    // Out-of-range write is dropped, then readback of every pad.
    wait_idle(); do_write(50, 8'hFF);
    read_all();

    // Write and commit accepted on the same edge.
    wait_idle();
    n0 = acc_cnt;
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(22); bus.wr_data = 8'hF1;
    bus.commit_valid = 1'b1;
    nxt();
    bus.wr_valid = 1'b0;
    wait_accept(n0);

    // Commit held high while busy is stalled until IDLE.
    wait_idle(); do_write(9, 8'h41);
    do_commit();
    bus.commit_valid = 1'b1;
    n0 = acc_cnt;
    nxt();
    wait_accept(n0);

    // Randomized writes (some while busy, some out of range) and commits.
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 3);
      for (int w = 0; w < n; w++) begin
        nxt();
        do_write($urandom_range(0, 55), $urandom_range(0, 255));
      end
      if ($urandom_range(0, 2) != 0) begin nxt(); do_commit(); end
      repeat ($urandom_range(0, 15)) nxt();
    end

    // Asynchronous reset in the second settle phase.
    wait_idle(); do_write(7, 8'h55);
    do_commit();
    n = 0;
    while ((cyc - c_a + 1) < SETTLE + 5 && n < 100) begin nxt(); n++; end
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_commit_done", 64'(bus.commit_done), 64'(0));
    chk("rst_commit_ready", 64'(bus.commit_ready), 64'(1));
    chk("rst_rd_data", 64'(bus.rd_data), 64'h02);
    chk("rst_pad_oe", 64'(pad_oe), 64'(0));
    chk("rst_pad_ie", 64'(pad_ie), {18'h0, {NPADS{1'b1}}});
    chk("rst_pad_pu", 64'(pad_pu), 64'(0));
    chk("rst_pad_cs", 64'(pad_cs), 64'(0));
    nxt(); nxt();
    rst = 1'b0;
    read_all();
    repeat (20) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
